// File: rtl/srlatch_driver.sv
// srlatch_driver: clocked front end that drives a four-phase s/r handshake into an asynchronous SR latch
module srlatch_driver #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic       cmd_set,
    output logic       cmd_ready,
    output logic       s,
    output logic       r,
    input  logic       ack,
    input  logic       q,
    output logic       busy,
    output logic       done_valid,
    output logic       done_q,
    output logic [1:0] done_err
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ASSERT, RELEASE, REPORT} state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] ack_sync, q_sync;
    logic                   ack_s, q_s;
    logic [CW-1:0]          cnt, cnt_n;
    logic                   cmd_reg, cmd_n, q_reg, q_n, s_n, r_n;
    logic [1:0]             err_reg, err_n;
    logic                   accept, timeout_hit, report_entry;

    assign ack_s        = ack_sync[SYNC_STAGES-1];
    assign q_s          = q_sync[SYNC_STAGES-1];
    assign accept       = cmd_valid && cmd_ready;
    assign timeout_hit  = (cnt == CW'(TIMEOUT - 1)) &&
                          ((state == ASSERT && !ack_s) || (state == RELEASE && ack_s));
    assign report_entry = (state == RELEASE) && (state_n == REPORT);

    // Bring the latch's ack and its bundled q into the clock domain
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack_sync <= '0;
            q_sync   <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack};
            q_sync   <= {q_sync[SYNC_STAGES-2:0], q};
        end
    end

    // Handshake state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Advance through the four phases; ack beats a coincident timeout
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = ASSERT;
            ASSERT:  if (ack_s || timeout_hit) state_n = RELEASE;
            RELEASE: if (!ack_s || timeout_hit) state_n = REPORT;
            default: state_n = IDLE;
        endcase
    end

    // Status outputs and next values of the registered datapath
    always_comb begin
        cmd_ready  = (state == IDLE) && !ack_s;
        busy       = state != IDLE;
        done_valid = state == REPORT;
        cmd_n      = (state == IDLE && accept) ? cmd_set : cmd_reg;
        s_n        = (state == IDLE) ? (accept && cmd_set) :
                     (state == ASSERT) ? (s && state_n == ASSERT) : 1'b0;
        r_n        = (state == IDLE) ? (accept && !cmd_set) :
                     (state == ASSERT) ? (r && state_n == ASSERT) : 1'b0;
        q_n        = (state == ASSERT && state_n == RELEASE) ? q_s : q_reg;
        err_n      = (state == IDLE && accept) ? 2'b00 :
                     (state == ASSERT && ack_s) ? {q_s != cmd_reg, err_reg[0]} :
                     timeout_hit ? (err_reg | 2'b01) : err_reg;
        cnt_n      = (state_n != state) ? '0 :
                     (state == ASSERT || state == RELEASE) ? cnt + 1'b1 : cnt;
    end

    // Request lines, phase timer and the per-transaction result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s        <= 1'b0;
            r        <= 1'b0;
            cnt      <= '0;
            cmd_reg  <= 1'b0;
            q_reg    <= 1'b0;
            err_reg  <= 2'b00;
            done_q   <= 1'b0;
            done_err <= 2'b00;
        end else begin
            s        <= s_n;
            r        <= r_n;
            cnt      <= cnt_n;
            cmd_reg  <= cmd_n;
            q_reg    <= q_n;
            err_reg  <= err_n;
            done_q   <= report_entry ? q_reg : done_q;
            done_err <= report_entry ? err_n : done_err;
        end
    end
endmodule

// File: doc/srlatch_driver.md
Name: srlatch_driver

Overview:
- Synchronous upstream stage for the asynchronous SR-latch block.
- Accepts set/reset commands over a clocked valid/ready interface.
- Drives the latch's s/r request lines with a four-phase, return-to-zero bundled-data handshake, and synchronises the latch's ack and q.
- Reports each completed transaction: captured q, plus timeout and mismatch flags.

Parameters:
- SYNC_STAGES, 2, flop stages in the ack and q synchronisers (minimum 2).
- TIMEOUT, 255, maximum clock cycles spent waiting in a handshake phase before abort (minimum 1).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- cmd_valid  input  1  command present
- cmd_set  input  1  1 = set latch (drive s), 0 = reset latch (drive r)
- cmd_ready  output  1  driver can accept a command this cycle
- s  output  1  set request to latch, registered
- r  output  1  reset request to latch, registered
- ack  input  1  latch acknowledge, asynchronous to clk
- q  input  1  latch state, asynchronous, bundled with ack
- busy  output  1  high in any state other than IDLE
- done_valid  output  1  one-cycle pulse, transaction finished
- done_q  output  1  q value captured at ack rise
- done_err  output  2  bit0 = timeout occurred, bit1 = captured q differs from cmd_set

Behaviour:
- Synchronous reset (rst_n=0 at a clk edge) clears the following:
  - state to IDLE
  - s, r, busy, done_valid, done_q and done_err to 0
  - synchroniser flops and timeout counter to 0
  - Reset mid-transaction drops s/r on that same edge; no done pulse is generated.
- ack_s and q_s are the SYNC_STAGES-deep synchronised copies. An ack edge is visible to the FSM SYNC_STAGES cycles after it is sampled.
- cmd_ready = (state==IDLE) && (ack_s==0). This is combinational from registered state and never asserts while the latch still acknowledges.
- The timeout counter has width clog2(TIMEOUT+1).
  - It clears on every state entry and increments each cycle in ASSERT and RELEASE.
  - timeout_hit = (cnt == TIMEOUT-1) while the wait condition is false.
- At most one of s and r is high at any time. Both are 0 outside ASSERT.
- FSM states:
  - IDLE:
    - On cmd_valid && cmd_ready, latch cmd_set into cmd_reg and clear err_reg.
    - Next cycle enter ASSERT with s=cmd_set and r=~cmd_set.
  - ASSERT:
    - If ack_s==1: capture q_s into q_reg and set err_reg[1] = (q_s != cmd_reg). Next cycle s=r=0 and state RELEASE.
    - Else if timeout_hit: set err_reg[0]. Next cycle s=r=0 and state RELEASE; q_reg takes q_s; err_reg[1] is not set.
  - RELEASE:
    - If ack_s==0, go to REPORT.
    - Else if timeout_hit, set err_reg[0] and go to REPORT.
  - REPORT:
    - done_valid=1 for exactly one cycle, with done_q=q_reg and done_err=err_reg.
    - Next state IDLE.
    - done_q/done_err hold their values until the next REPORT. done_valid has no backpressure.
- If ack arrival and timeout_hit coincide, ack wins and no timeout is flagged.
- Minimum transaction length with an instant latch: 1 (accept) + SYNC_STAGES + 1 (ASSERT exit) + SYNC_STAGES + 1 (RELEASE exit) + 1 (REPORT) cycles. For the default SYNC_STAGES=2 this is 8 cycles from accept to done_valid.
- After REPORT the driver is back in IDLE. A held cmd_valid is accepted in the first IDLE cycle with ack_s==0, so commands can run back-to-back with one idle cycle between REPORT and the next accept.
- ack high in IDLE (for example after a RELEASE timeout) blocks acceptance until ack_s returns to 0.
- cmd_set and cmd_valid are ignored outside IDLE.

Test Plan:
- Set command: cmd_set=1, latch model raises ack with q=1 three cycles after s, drops ack three cycles after s falls.
  - Required: s pulses, r stays 0, single done_valid with done_q=1, done_err=00.
- Reset command after the set: cmd_set=0, model returns q=0.
  - Required: r pulses, s stays 0, done_q=0, done_err=00, cmd_ready low from accept through REPORT.
- Ack never rises, TIMEOUT=8.
  - Required: s drops after 8 ASSERT cycles, RELEASE exits immediately, done_err=01.
- Ack stuck high after the set.
  - Required: RELEASE times out, done_err=01, cmd_ready stays 0 until ack is released and synchronised.
- Mismatch: cmd_set=1 but model returns q=0 with ack.
  - Required: done_q=0, done_err=10.
- rst_n=0 for one cycle while s=1 in ASSERT.
  - Required: s=0 after that edge, no done_valid, busy=0, and a fresh command is then accepted and completes normally.
- cmd_valid held high for three commands (1,0,1).
  - Required: three done pulses in order with done_q 1,0,1, and s/r never high simultaneously.
